// File: rtl/mips_run_controller_if.sv
// rtl/mips_run_controller_if.sv - host command channel for the MIPS run/step controller
interface mips_run_controller_if #(
   parameter int CNT_WIDTH = 32
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd_op;
   logic [CNT_WIDTH-1:0] cmd_count;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_count,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_count,
      output cmd_ready
   );
endinterface

// File: rtl/mips_run_controller.sv
// rtl/mips_run_controller.sv - run/step/budget/breakpoint commit-enable controller for the MIPS core
// Breakpoint support is built only when MIPS_RUNCTL_BREAKPOINT_EN is defined.
module mips_run_controller #(
   parameter int PC_WIDTH  = 32,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   mips_run_controller_if.slave cmd,
   input  logic [PC_WIDTH-1:0]  pc,
   input  logic                 halt_req,
   input  logic                 bp_valid,
   input  logic [PC_WIDTH-1:0]  bp_addr,
   output logic                 cpu_en,
   output logic                 running,
   output logic                 stop_pulse,
   output logic [1:0]           stop_cause,
   output logic [CNT_WIDTH-1:0] cycle_count
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_COUNT = 2'd2
   } state_t;

   localparam logic [1:0] OP_HALT  = 2'b00;
   localparam logic [1:0] OP_STEP  = 2'b01;
   localparam logic [1:0] OP_RUN   = 2'b10;
   localparam logic [1:0] OP_RUN_N = 2'b11;

   localparam logic [1:0] CAUSE_HOST   = 2'b00;
   localparam logic [1:0] CAUSE_BUDGET = 2'b01;
   localparam logic [1:0] CAUSE_HALT   = 2'b10;
   localparam logic [1:0] CAUSE_BP     = 2'b11;

   state_t               state;
   logic [CNT_WIDTH-1:0] remaining;
   logic                 cmd_ready_q;
   logic                 bp_hit;
   logic                 stop_now;
   logic [1:0]           stop_code;

`ifdef MIPS_RUNCTL_BREAKPOINT_EN
   // skip lets a resume from the breakpoint PC execute that instruction once
   logic skip;
   assign bp_hit = bp_valid && (pc == bp_addr) && !skip;
`else
   logic unused_bp;
   assign unused_bp = ^{bp_valid, bp_addr, pc};
   assign bp_hit    = 1'b0;
`endif

   assign cpu_en        = (state != S_IDLE) && !bp_hit;
   assign cmd.cmd_ready = cmd_ready_q;

   // Stop events in priority order: breakpoint, halt instruction, budget, host HALT
   always_comb begin
      stop_now  = 1'b0;
      stop_code = CAUSE_HOST;
      if (state != S_IDLE) begin
         if (bp_hit) begin
            stop_now  = 1'b1;
            stop_code = CAUSE_BP;
         end else if (cpu_en && halt_req) begin
            stop_now  = 1'b1;
            stop_code = CAUSE_HALT;
         end else if (cpu_en && (state == S_COUNT) && (remaining == CNT_WIDTH'(1))) begin
            stop_now  = 1'b1;
            stop_code = CAUSE_BUDGET;
         end else if (cmd.cmd_valid && (cmd.cmd_op == OP_HALT)) begin
            stop_now  = 1'b1;
            stop_code = CAUSE_HOST;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         remaining   <= '0;
         cmd_ready_q <= 1'b1;
         running     <= 1'b0;
         stop_pulse  <= 1'b0;
         stop_cause  <= CAUSE_HOST;
         cycle_count <= '0;
`ifdef MIPS_RUNCTL_BREAKPOINT_EN
         skip        <= 1'b0;
`endif
      end else begin
         cmd_ready_q <= 1'b1;
         stop_pulse  <= 1'b0;
         if (cpu_en) begin
            cycle_count <= cycle_count + 1'b1;
`ifdef MIPS_RUNCTL_BREAKPOINT_EN
            skip        <= 1'b0;
`endif
         end
         case (state)
            S_IDLE: begin
               if (cmd.cmd_valid) begin
                  case (cmd.cmd_op)
                     OP_STEP: begin
                        state     <= S_COUNT;
                        running   <= 1'b1;
                        remaining <= CNT_WIDTH'(1);
`ifdef MIPS_RUNCTL_BREAKPOINT_EN
                        skip      <= 1'b1;
`endif
                     end
                     OP_RUN: begin
                        state   <= S_RUN;
                        running <= 1'b1;
`ifdef MIPS_RUNCTL_BREAKPOINT_EN
                        skip    <= 1'b1;
`endif
                     end
                     OP_RUN_N: begin
                        if (cmd.cmd_count != '0) begin
                           state     <= S_COUNT;
                           running   <= 1'b1;
                           remaining <= cmd.cmd_count;
`ifdef MIPS_RUNCTL_BREAKPOINT_EN
                           skip      <= 1'b1;
`endif
                        end
                     end
                     default: ;
                  endcase
               end
            end
            default: begin
               if (stop_now) begin
                  state      <= S_IDLE;
                  running    <= 1'b0;
                  stop_pulse <= 1'b1;
                  stop_cause <= stop_code;
                  remaining  <= '0;
               end else if ((state == S_COUNT) && cpu_en) begin
                  remaining <= remaining - 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: doc/mips_run_controller.md
# mips_run_controller

Run/step controller for the single-cycle MIPS core. Sits between the free-running testbench `clock` and the datapath and produces `cpu_en`, the commit enable for PC, register file and data memory writes. A host (testbench or debug port) issues HALT, STEP, RUN and RUN_N commands over a valid/ready handshake. The block stops the core on command, on cycle-budget expiry, on a halt instruction, or on a PC breakpoint, and it counts executed cycles.

## Interface
- `PC_WIDTH`, 32, width of PC and breakpoint address
- `CNT_WIDTH`, 32, width of cycle budget and cycle counter

- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted this edge when high with `cmd_valid`
- `cmd_op`  in  2  00 HALT, 01 STEP, 10 RUN, 11 RUN_N
- `cmd_count`  in  CNT_WIDTH  cycle budget for RUN_N
- `pc`  in  PC_WIDTH  current datapath PC
- `halt_req`  in  1  datapath decoded halt instruction this cycle
- `bp_valid`  in  1  breakpoint armed
- `bp_addr`  in  PC_WIDTH  breakpoint PC
- `cpu_en`  out  1  datapath commit enable
- `running`  out  1  state is not IDLE
- `stop_pulse`  out  1  one-cycle pulse after each stop
- `stop_cause`  out  2  00 host HALT, 01 budget done, 10 halt instruction, 11 breakpoint
- `cycle_count`  out  CNT_WIDTH  cycles with `cpu_en` high since reset

## Operation
- The state machine has three states:
  - IDLE: no execution.
  - RUN: unbounded execution.
  - COUNT: bounded execution with a `remaining` register.
- Reset (asynchronous, immediate) puts the block in IDLE. Output reset values:
  - `cpu_en`=0, `running`=0, `stop_pulse`=0, `stop_cause`=00, `cycle_count`=0.
  - `cmd_ready`=1.
- `cmd_ready` is constantly 1 outside reset. Commands are never stalled.
- Commands in IDLE:
  - STEP goes to COUNT with `remaining`=1.
  - RUN goes to RUN.
  - RUN_N with `cmd_count`≠0 goes to COUNT with `remaining`=`cmd_count`.
  - RUN_N with count 0 and HALT are no-ops. No pulse is issued.
- Commands in RUN/COUNT:
  - HALT goes to IDLE with cause 00.
  - STEP, RUN and RUN_N are accepted and discarded.
- `cpu_en` = (state≠IDLE) && !bp_hit. It is the only combinational output.
- In COUNT, each edge with `cpu_en`=1 decrements `remaining`. When `remaining`=1 at that edge, the state goes to IDLE with cause 01.
- `halt_req` is sampled only while `cpu_en`=1. The halting cycle commits, then the state goes to IDLE with cause 10.
- Breakpoint:
  - bp_hit = `bp_valid` && `pc`==`bp_addr` && !skip.
  - On a hit, `cpu_en` is low that cycle and the state goes to IDLE with cause 11.
  - `skip` sets on command acceptance that leaves IDLE and clears after the first `cpu_en` cycle. Resuming from a breakpoint PC therefore executes it.
- Simultaneous stop events use this priority: breakpoint 11 > halt_req 10 > budget 01 > HALT command 00.
- `cycle_count` increments on every edge with `cpu_en`=1 and wraps from all-ones to 0.

## Timing
- A command accepted at edge k drives `cpu_en` high in cycle k+1. There is no bubble.
- RUN_N N yields exactly N consecutive `cpu_en` cycles, absent other stops.
- A HALT command accepted at edge k leaves cycle k enabled. `cpu_en` is low from cycle k+1.
- `stop_pulse` is registered, high for exactly the one cycle after the transition to IDLE. `stop_cause` updates on the same edge and holds until the next stop.
- Asserting `reset_n` low mid-run drops `cpu_en` asynchronously. `remaining` is cleared.

## Configuration
- `MIPS_RUNCTL_BREAKPOINT_EN` defined: breakpoint compare, `skip` flag and cause 11 are implemented.
- Undefined: `bp_valid` and `bp_addr` stay as ports but are ignored. bp_hit is constant 0. Cause 11 is never produced.

## Test plan
- Reset release, then RUN_N with count 5 -> `cpu_en` high exactly 5 cycles starting the cycle after acceptance. `stop_pulse` is high one cycle with cause 01. `cycle_count`=5.
- RUN, then HALT accepted 10 cycles later -> 11 enabled cycles, cause 00. A RUN_N sent mid-run is ignored.
- RUN with `halt_req` pulsed on the 4th enabled cycle -> 4 enabled cycles, cause 10. Simultaneous HALT on that cycle still reports 10.
- Macro on, `bp_addr`=0x0040_0010, `pc` stepping by 4 from 0x0040_0000, RUN -> 4 enabled cycles, stop with `cpu_en` low at 0x...10, cause 11. A following STEP executes 0x...10 exactly once.
- Preload `cycle_count` near all-ones via RUN_N 2^CNT_WIDTH−1 with CNT_WIDTH=4 -> count wraps 15→0 on the 16th enabled cycle.
- `reset_n` pulsed low mid-RUN -> `cpu_en`=0 immediately. All outputs return to reset values, and RUN is required to restart.
